// File: rtl/enemy_patrol.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | enemy_patrol: one walking enemy that patrols [X_MIN, X_MAX], can be stomped, |
// | and kills the player on side contact. Optional respawn: ENEMY_RESPAWN_EN.    |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module enemy_patrol #(
    parameter int X_START        = 160,
    parameter int Y_POS          = 36,
    parameter int X_MIN          = 120,
    parameter int X_MAX          = 200,
    parameter int SIZE           = 12,
    parameter int STEP_DIV       = 500000,
    parameter int SQUISH_CYCLES  = 25000000,
    parameter int RESPAWN_CYCLES = 100000000,
    parameter int CNT_W          = 27
) (
    input  logic       sys_clk,
    input  logic       RST_N,
    input  logic [9:0] char_X,
    input  logic [9:0] char_Y,
    input  logic [9:0] bg_pos,
    input  logic       freeze,
    output logic [9:0] goomba_x,
    output logic [9:0] goomba_y,
    output logic       death,
    output logic       en,
    output logic       squished,
    output logic       dir
);

    typedef enum logic [1:0] {
        WALK_L = 2'd0,
        WALK_R = 2'd1,
        SQUISH = 2'd2,
        GONE   = 2'd3
    } state_t;

    localparam logic [10:0] c_SIZE   = 11'(SIZE);
    localparam logic [10:0] c_Y_POS  = 11'(Y_POS);
    localparam logic [9:0]  c_X_MIN  = 10'(X_MIN);
    localparam logic [9:0]  c_X_MAX  = 10'(X_MAX);
    localparam logic [9:0]  c_X_INIT = 10'(X_START);

    state_t             state_q, state_d;
    logic [9:0]         ex_q, ex_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               death_q, death_d;
    logic               dir_q, dir_d;

    logic [10:0]        w_cx;
    logic [10:0]        w_cy;
    logic [10:0]        w_ex;
    logic               w_ovl;
    logic               w_stomp;
    logic               w_side;
    logic [CNT_W-1:0]   w_cnt_last;
    logic               w_tc;

    // 11-bit operands so that position + SIZE can never wrap
    assign w_cx    = {1'b0, char_X};
    assign w_cy    = {1'b0, char_Y};
    assign w_ex    = {1'b0, ex_q};
    assign w_ovl   = (w_cx + c_SIZE >= w_ex) && (w_cx <= w_ex + c_SIZE);
    assign w_stomp = w_ovl && (w_cy + c_SIZE == c_Y_POS);
    assign w_side  = w_ovl && (w_cy == c_Y_POS);

`ifdef ENEMY_RESPAWN_EN
    localparam logic [10:0] c_X_INIT11 = 11'(X_START);
    logic w_spawn_blk;

    assign w_spawn_blk = (w_cx + c_SIZE >= c_X_INIT11) && (w_cx <= c_X_INIT11 + c_SIZE)
                      && (w_cy + c_SIZE >= c_Y_POS)    && (w_cy <= c_Y_POS + c_SIZE);
`endif

    // One counter serves as step divider, squish timer and respawn timer
    always_comb begin
        w_cnt_last = CNT_W'(RESPAWN_CYCLES - 1);
        case (state_q)
            WALK_L, WALK_R: w_cnt_last = CNT_W'(STEP_DIV - 1);
            SQUISH:         w_cnt_last = CNT_W'(SQUISH_CYCLES - 1);
            default:        w_cnt_last = CNT_W'(RESPAWN_CYCLES - 1);
        endcase
    end

    assign w_tc = (cnt_q == w_cnt_last);

    always_ff @(posedge sys_clk or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= WALK_L;
            ex_q    <= c_X_INIT;
            cnt_q   <= '0;
            death_q <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ex_q    <= ex_d;
            cnt_q   <= cnt_d;
            death_q <= death_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ex_d    = ex_q;
        cnt_d   = cnt_q;
        death_d = 1'b0;
        dir_d   = dir_q;
        case (state_q)
            WALK_L, WALK_R: begin
                death_d = w_side;
                // A stomp beats any step or turn landing in the same cycle
                if (w_stomp) begin
                    state_d = SQUISH;
                    cnt_d   = '0;
                end else if (!freeze) begin
                    if (w_tc) begin
                        cnt_d = '0;
                        if (state_q == WALK_L) begin
                            if (ex_q == c_X_MIN) begin
                                state_d = WALK_R;
                                dir_d   = 1'b1;
                            end else begin
                                ex_d = ex_q - 10'd1;
                            end
                        end else begin
                            if (ex_q == c_X_MAX) begin
                                state_d = WALK_L;
                                dir_d   = 1'b0;
                            end else begin
                                ex_d = ex_q + 10'd1;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            SQUISH: begin
                if (!freeze) begin
                    if (w_tc) begin
                        cnt_d   = '0;
                        state_d = GONE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            GONE: begin
`ifdef ENEMY_RESPAWN_EN
                // Counter parks on its last value while the spawn box is occupied
                if (!freeze) begin
                    if (w_tc) begin
                        if (!w_spawn_blk) begin
                            cnt_d   = '0;
                            ex_d    = c_X_INIT;
                            state_d = WALK_L;
                            dir_d   = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`else
                state_d = GONE;
`endif
            end
            default: state_d = WALK_L;
        endcase
    end

    assign goomba_x = ex_q - bg_pos;
    assign goomba_y = 10'(Y_POS);
    assign death    = death_q;
    assign en       = (state_q != GONE);
    assign squished = (state_q == SQUISH);
    assign dir      = dir_q;

endmodule
`default_nettype wire

// File: tb/tb_enemy_patrol.sv
`default_nettype none
`timescale 1ns/1ps
// +-----------------------------------------------------------------------------+
// | tb_enemy_patrol: directed self-checking bench for enemy_patrol.              |
// | Revision: 1.0                                                                |
// +-----------------------------------------------------------------------------+
module tb_enemy_patrol;

    logic       sys_clk;
    logic       RST_N;
    logic [9:0] char_X;
    logic [9:0] char_Y;
    logic [9:0] bg_pos;
    logic       freeze;
    logic [9:0] goomba_x;
    logic [9:0] goomba_y;
    logic       death;
    logic       en;
    logic       squished;
    logic       dir;

    int errors;
    int checks;

    enemy_patrol #(
        .X_START        (160),
        .Y_POS          (36),
        .X_MIN          (158),
        .X_MAX          (162),
        .SIZE           (12),
        .STEP_DIV       (4),
        .SQUISH_CYCLES  (8),
        .RESPAWN_CYCLES (16),
        .CNT_W          (27)
    ) dut (
        .sys_clk  (sys_clk),
        .RST_N    (RST_N),
        .char_X   (char_X),
        .char_Y   (char_Y),
        .bg_pos   (bg_pos),
        .freeze   (freeze),
        .goomba_x (goomba_x),
        .goomba_y (goomba_y),
        .death    (death),
        .en       (en),
        .squished (squished),
        .dir      (dir)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        RST_N  = 1'b1;
        char_X = 10'd0;
        char_Y = 10'd0;
        bg_pos = 10'd0;
        freeze = 1'b0;

        #1 RST_N = 1'b0;
        #1;
        chk("rst_x", goomba_x, 10'd160);
        chk("rst_y", goomba_y, 10'd36);
        chk("rst_en", en, 1'b1);
        chk("rst_sq", squished, 1'b0);
        chk("rst_dir", dir, 1'b0);
        chk("rst_death", death, 1'b0);

        @(posedge sys_clk);
        #1 RST_N = 1'b1;

        // patrol left to X_MIN, turn, right to X_MAX, turn
        tick(3);  chk("walk_hold", goomba_x, 10'd160);
        tick(1);  chk("walk_159", goomba_x, 10'd159);
        tick(4);  chk("walk_158", goomba_x, 10'd158);
        tick(4);  chk("turn_min_x", goomba_x, 10'd158);
                  chk("turn_min_dir", dir, 1'b1);
        tick(4);  chk("walk_r_159", goomba_x, 10'd159);
        for (int i = 0; i < 12; i++) begin
            tick(1);
            chk("range", 10'((goomba_x >= 10'd158) && (goomba_x <= 10'd162)), 10'd1);
        end
        chk("walk_162", goomba_x, 10'd162);
        chk("walk_162_dir", dir, 1'b1);
        tick(4);  chk("turn_max_x", goomba_x, 10'd162);
                  chk("turn_max_dir", dir, 1'b0);
        tick(4);  chk("walk_l_161", goomba_x, 10'd161);
        tick(4);  chk("walk_l_160", goomba_x, 10'd160);

        // side contact
        char_X = 10'd150; char_Y = 10'd36;
        tick(1);  chk("side_death", death, 1'b1);
        tick(1);  chk("side_persist", death, 1'b1);
                  chk("side_en", en, 1'b1);
        char_X = 10'd140;
        tick(1);  chk("side_clear", death, 1'b0);
                  chk("side_clear_en", en, 1'b1);
                  chk("side_x", goomba_x, 10'd160);

        // freeze with counter at its last value: no step until released
        char_X = 10'd0; char_Y = 10'd0; freeze = 1'b1;
        tick(10); chk("frz_x", goomba_x, 10'd160);
                  chk("frz_sq", squished, 1'b0);
        freeze = 1'b0;
        tick(1);  chk("unfrz_step", goomba_x, 10'd159);
        tick(4);  chk("unfrz_158", goomba_x, 10'd158);
        tick(4);  chk("unfrz_turn_dir", dir, 1'b1);
        tick(4);  chk("unfrz_159", goomba_x, 10'd159);

        // stomp while frozen, walking right
        freeze = 1'b1; char_X = 10'd165; char_Y = 10'd24;
        tick(1);  chk("frz_stomp_sq", squished, 1'b1);
                  chk("frz_stomp_x", goomba_x, 10'd159);
                  chk("frz_stomp_dir", dir, 1'b1);
                  chk("frz_stomp_death", death, 1'b0);
        tick(3);  chk("frz_squish_hold", squished, 1'b1);

        // asynchronous reset mid-SQUISH
        #2 RST_N = 1'b0;
        #1;
        chk("arst_x", goomba_x, 10'd160);
        chk("arst_en", en, 1'b1);
        chk("arst_sq", squished, 1'b0);
        chk("arst_dir", dir, 1'b0);
        chk("arst_death", death, 1'b0);
        freeze = 1'b0; char_X = 10'd0; char_Y = 10'd0;
        @(posedge sys_clk);
        #1 RST_N = 1'b1;

        // stomp on a step cycle: ex must not move
        tick(3);  chk("pre_stomp_x", goomba_x, 10'd160);
        char_X = 10'd165; char_Y = 10'd24;
        tick(1);  chk("stomp_sq", squished, 1'b1);
                  chk("stomp_x", goomba_x, 10'd160);
                  chk("stomp_death", death, 1'b0);
                  chk("stomp_en", en, 1'b1);
        char_X = 10'd0; char_Y = 10'd0;
        tick(7);  chk("squish_7", squished, 1'b1);
        tick(1);  chk("gone_en", en, 1'b0);
                  chk("gone_sq", squished, 1'b0);
                  chk("gone_x", goomba_x, 10'd160);
                  chk("gone_death", death, 1'b0);
        bg_pos = 10'd200;
        #1 chk("scroll_wrap", goomba_x, 10'd984);
        bg_pos = 10'd0;

`ifdef ENEMY_RESPAWN_EN
        tick(15); chk("gone_15", en, 1'b0);
        tick(1);  chk("respawn_en", en, 1'b1);
                  chk("respawn_x", goomba_x, 10'd160);
                  chk("respawn_dir", dir, 1'b0);
                  chk("respawn_sq", squished, 1'b0);
        char_X = 10'd165; char_Y = 10'd24;
        tick(1);  chk("stomp2_sq", squished, 1'b1);
        char_X = 10'd160; char_Y = 10'd36;
        tick(8);  chk("gone2_en", en, 1'b0);
        tick(16); chk("blocked_en", en, 1'b0);
                  chk("blocked_death", death, 1'b0);
        char_X = 10'd0; char_Y = 10'd0;
        tick(1);  chk("unblocked_en", en, 1'b1);
                  chk("unblocked_x", goomba_x, 10'd160);
`else
        for (int i = 0; i < 1000; i++) begin
            tick(1);
            chk("gone_terminal", en, 1'b0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
